decode_issue: RTL and testbench

//  Decode/issue stage of the uRISC core; it is the producer side of the ID->IX pipeline register.

---
 rtl/urisc_pkg.sv | 23 ++
 rtl/issue_queue.sv | 42 ++++
 rtl/decode_issue.sv | 76 +++++++
 tb/tb_decode_issue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/urisc_pkg.sv
// urisc_pkg: shared opcode constants, uop classes and decode helpers for the uRISC core
package urisc_pkg;
  localparam int UOPW_DEFAULT = 26;
  typedef logic [4:0] opcode_t;
  localparam opcode_t OP_ST   = 5'b10000;
  localparam opcode_t OP_SLBI = 5'b10010;
  localparam opcode_t OP_LBI  = 5'b11000;
  typedef enum logic [2:0] {CLS_ALU, CLS_LDST, CLS_JMP, CLS_BR, CLS_SPEC} uop_class_e;
  function automatic uop_class_e op_class(input opcode_t op);
    return op[4:2] == 3'b000 ? CLS_SPEC :
           op[4:2] == 3'b001 ? CLS_JMP :
           op[4:2] == 3'b011 ? CLS_BR :
           (op[4:2] == 3'b100 && op != OP_SLBI) ? CLS_LDST : CLS_ALU;
  endfunction
  function automatic logic [2:0] rd_sel(input opcode_t op, input logic [15:0] instr);
    return op[4:3] == 2'b00 ? (op[2:1] == 2'b11 ? 3'd7 : 3'd0) :
           op[4:2] == 3'b011 ? 3'd0 :
           op == OP_ST ? 3'd0 :
           (op == OP_SLBI || op == OP_LBI) ? instr[10:8] :
           op[4:2] == 3'b100 ? instr[7:5] :
           (op[4:1] == 4'b1101 || op[4:2] == 3'b111) ? instr[4:2] : instr[7:5];
  endfunction
endpackage

// File: rtl/issue_queue.sv
// issue_queue: small FIFO skid buffer with a registered ready (not full) and flush
module issue_queue #(
  parameter int QDEPTH = 2,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         ready,
  output logic         empty
);
  localparam int AW = $clog2(QDEPTH);
  logic [W-1:0] mem [QDEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign do_push = push && ready && !flush;
  assign do_pop = pop && !empty && !flush;
  assign cnt_n = flush ? '0 : cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout = mem[rp];
  // pointers, occupancy and the registered ready track pushes, pops and flushes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ready <= 1'b0;
    end else begin
      wp <= flush ? '0 : wp + AW'(do_push);
      rp <= flush ? '0 : rp + AW'(do_pop);
      cnt <= cnt_n;
      ready <= cnt_n != (AW+1)'(QDEPTH);
    end
  // storage write on accepted push
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/decode_issue.sv
// decode_issue: buffers fetched instructions, decodes them and drives the ID->IX register
module decode_issue
  import urisc_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int UOPW = UOPW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instr_ifid_p0,
  input  logic            instr_valid_ifid_p0,
  output logic            instr_ready_ifid_p0,
  input  logic            ix_stall_p1,
  input  logic            flush_ix_p1,
  output logic [2:0]      rs_idix_p1,
  output logic [2:0]      rt_idix_p1,
  output logic [2:0]      rd_idix_p1,
  output logic [UOPW-1:0] uop_cnt_idix_p1,
  output logic            execute_valid_idix_p1,
  output logic            ldst_valid_idix_p1,
  output logic            jmp_idix_p1,
  output logic            branch_idix_p1,
  output logic [4:0]      opcode_idix_p1
);
  logic [15:0] q_head;
  logic q_empty, advance, q_pop;
  logic [UOPW-1:0] cnt;
  opcode_t op;
  uop_class_e cls;
  logic [2:0] rd_n;
  assign advance = !execute_valid_idix_p1 || !ix_stall_p1;
  assign q_pop = advance && !q_empty;
  assign op = q_head[15:11];
  assign cls = op_class(op);
  assign rd_n = rd_sel(op, q_head);
  issue_queue #(.QDEPTH(QDEPTH), .W(16)) u_q (
    .clk(clk),
    .rst(rst),
    .push(instr_valid_ifid_p0),
    .din(instr_ifid_p0),
    .pop(q_pop),
    .flush(flush_ix_p1),
    .dout(q_head),
    .ready(instr_ready_ifid_p0),
    .empty(q_empty)
  );
  // output stage: flush drops valid, advance loads the decoded head or goes idle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rs_idix_p1 <= '0;
      rt_idix_p1 <= '0;
      rd_idix_p1 <= '0;
      uop_cnt_idix_p1 <= '0;
      execute_valid_idix_p1 <= 1'b0;
      ldst_valid_idix_p1 <= 1'b0;
      jmp_idix_p1 <= 1'b0;
      branch_idix_p1 <= 1'b0;
      opcode_idix_p1 <= '0;
      cnt <= '0;
    end else if (flush_ix_p1) begin
      execute_valid_idix_p1 <= 1'b0;
    end else if (advance) begin
      execute_valid_idix_p1 <= !q_empty;
      if (!q_empty) begin
        opcode_idix_p1 <= op;
        rs_idix_p1 <= q_head[10:8];
        rt_idix_p1 <= q_head[7:5];
        rd_idix_p1 <= rd_n;
        ldst_valid_idix_p1 <= cls == CLS_LDST;
        jmp_idix_p1 <= cls == CLS_JMP;
        branch_idix_p1 <= cls == CLS_BR;
        uop_cnt_idix_p1 <= cnt;
        cnt <= cnt + UOPW'(1);
      end
    end
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed self-checking bench for decode_issue
module tb_decode_issue;
  logic clk, rst, ivalid, ready, stall, flush, ev, ldst, jmp, br;
  logic [15:0] instr;
  logic [2:0] rs, rt, rd;
  logic [25:0] uop;
  logic [4:0] opc;
  int n_cmp = 0;
  int n_bad = 0;

  decode_issue dut (
    .clk(clk),
    .rst(rst),
    .instr_ifid_p0(instr),
    .instr_valid_ifid_p0(ivalid),
    .instr_ready_ifid_p0(ready),
    .ix_stall_p1(stall),
    .flush_ix_p1(flush),
    .rs_idix_p1(rs),
    .rt_idix_p1(rt),
    .rd_idix_p1(rd),
    .uop_cnt_idix_p1(uop),
    .execute_valid_idix_p1(ev),
    .ldst_valid_idix_p1(ldst),
    .jmp_idix_p1(jmp),
    .branch_idix_p1(br),
    .opcode_idix_p1(opc)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] t3_i [5] = '{16'h8000, 16'h3000, 16'h6000, 16'h9400, 16'h88E0};
  logic [5:0]  t3_e [5] = '{6'b100_000, 6'b010_111, 6'b001_000, 6'b000_100, 6'b100_111};

  initial begin
    rst = 0; instr = 0; ivalid = 0; stall = 0; flush = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", ev, 0);
    chk("rst_ready", ready, 0);
    chk("rst_uop", uop, 0);
    chk("rst_fields", {ldst, jmp, br, rs, rt, rd, opc}, 0);
    rst = 1;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);

    // single ADD, latency two cycles
    instr = 16'hD9A8; ivalid = 1;
    @(negedge clk);
    ivalid = 0;
    chk("t1_n1_valid", ev, 0);
    @(negedge clk);
    chk("t1_valid", ev, 1);
    chk("t1_opcode", opc, 5'h1B);
    chk("t1_rs_rt_rd", {rs, rt, rd}, {3'd1, 3'd5, 3'd2});
    chk("t1_uop", uop, 0);
    chk("t1_class", {ldst, jmp, br}, 0);
    @(negedge clk);
    chk("t1_idle", ev, 0);

    // three back-to-back under stall
    stall = 1; instr = 16'h4260; ivalid = 1;
    @(negedge clk);
    instr = 16'hE3A4;
    @(negedge clk);
    instr = 16'hC500;
    chk("t2_first_valid", ev, 1);
    chk("t2_first_uop", uop, 1);
    @(negedge clk);
    ivalid = 0;
    chk("t2_ready_full", ready, 0);
    chk("t2_frozen_uop", uop, 1);
    @(negedge clk);
    chk("t2_frozen_valid", ev, 1);
    chk("t2_frozen_fields", {opc, rs, rt, rd, uop}, {5'h08, 3'd2, 3'd3, 3'd3, 26'd1});
    chk("t2_still_full", ready, 0);
    stall = 0;
    @(negedge clk);
    chk("t2_b", {ev, opc, rs, rt, rd, uop}, {1'b1, 5'h1C, 3'd3, 3'd5, 3'd1, 26'd2});
    chk("t2_ready_back", ready, 1);
    @(negedge clk);
    chk("t2_c", {ev, opc, rs, rt, rd, uop}, {1'b1, 5'h18, 3'd5, 3'd0, 3'd5, 26'd3});
    @(negedge clk);
    chk("t2_drained", ev, 0);

    // class decode: ST, JAL, BEQZ, SLBI, LD
    for (int k = 0; k < 7; k++) begin
      if (k >= 2) begin
        chk("t3_valid", ev, 1);
        chk("t3_class_rd", {ldst, jmp, br, rd}, t3_e[k-2]);
        chk("t3_uop", uop, 4 + k - 2);
      end
      if (k < 5) begin
        instr = t3_i[k]; ivalid = 1;
      end else ivalid = 0;
      @(negedge clk);
    end
    chk("t3_drained", ev, 0);

    // fill under stall, flush with push attempts
    stall = 1; instr = 16'h4000; ivalid = 1;
    @(negedge clk);
    instr = 16'h4020;
    @(negedge clk);
    instr = 16'h4040;
    chk("t4_out_uop", uop, 9);
    @(negedge clk);
    chk("t4_full", ready, 0);
    instr = 16'h4060; flush = 1;
    @(negedge clk);
    chk("t4_flush_valid", ev, 0);
    chk("t4_flush_ready", ready, 1);
    instr = 16'h4080;
    @(negedge clk);
    flush = 0; ivalid = 0; stall = 0;
    chk("t4_flush2_valid", ev, 0);
    @(negedge clk);
    chk("t4_empty_after_flush", ev, 0);
    instr = 16'hE3A4; ivalid = 1;
    @(negedge clk);
    ivalid = 0;
    @(negedge clk);
    chk("t4_next_uop", {ev, uop}, {1'b1, 26'd10});

    // counter wrap
    @(negedge clk);
    force dut.cnt = '1;
    #1 release dut.cnt;
    instr = 16'h4260; ivalid = 1;
    @(negedge clk);
    instr = 16'hE3A4;
    @(negedge clk);
    ivalid = 0;
    chk("t5_max", {ev, uop}, {1'b1, 26'h3FFFFFF});
    @(negedge clk);
    chk("t5_wrap", {ev, uop}, {1'b1, 26'h0});

    // async reset during stall
    stall = 1; instr = 16'hD9A8; ivalid = 1;
    @(negedge clk);
    ivalid = 0;
    @(negedge clk);
    chk("t6_held_valid", ev, 1);
    #2 rst = 0;
    #1;
    chk("t6_async_valid", ev, 0);
    chk("t6_async_fields", {uop, opc, rs, rt, rd, ldst, jmp, br}, 0);
    chk("t6_async_ready", ready, 0);
    @(negedge clk);
    rst = 1; stall = 0;
    @(negedge clk);
    chk("t6_ready_after", ready, 1);
    chk("t6_valid_after", ev, 0);
    instr = 16'h4260; ivalid = 1;
    @(negedge clk);
    ivalid = 0;
    @(negedge clk);
    chk("t6_cnt_restart", {ev, uop}, {1'b1, 26'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
